// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port GPR file: default geometry,
// the register index type and the architecturally special registers.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    // $0 is hardwired to zero; $ra is the link register for jal/jalr.
    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Issue marks a destination busy; the
// completing write-back clears it. A new producer issued in the same cycle
// as the old one completes keeps the register busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NWR    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  any_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_next;

    // Clears from write-back first, then the issue set on top so it wins; $0 never busy.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (sb_set) begin
            busy_next[sb_addr] = 1'b1;
        end
        busy_next[ADDR_W'(REG_ZERO)] = 1'b0;
    end

    // Busy vector register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with same-cycle write-to-read bypass and a busy
// scoreboard. Optional write trace enabled by defining REGFILE_TRACE_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [NWR*32-1:0]     wr_pc,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic                  any_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Storage: later (higher-index) ports override earlier ones on the same address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
                    rf[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NWR    (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .any_busy (any_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              hit;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Read mux with forwarding from the write ports; $0 and reset force zero.
        always_comb begin
            data = rf[addr];
            hit  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
                    data = wr_data[j*DATA_W +: DATA_W];
                    hit  = 1'b1;
                end
            end
            if ((addr == ADDR_W'(REG_ZERO)) || !reset) begin
                data = '0;
                hit  = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i] = reset & busy[addr] & ~hit;
    end

`ifdef REGFILE_TRACE_EN
    // Trace every enabled write port in index order, including writes to $0.
    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    $display("%d@%h: $%d <= %h", $time, wr_pc[j*32 +: 32],
                             wr_addr[j*ADDR_W +: ADDR_W], wr_data[j*DATA_W +: DATA_W]);
                end
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^wr_pc;
`endif

endmodule
